// File: rtl/oflow_mem_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : oflow_mem_buffer_arbiter
// Brief    : Round-robin write/read burst arbiter for a single-port buffer.
// Revision : 1.0 - initial release
// ============================================================================
module oflow_mem_buffer_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_base,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              wr_beat,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_base,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [3:0]        beat_q, beat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              last_rd_q, last_rd_d;
  logic              rd_valid_q;

  logic arb_point;
  logic last_is_rd;
  logic grant_wr;
  logic grant_rd;

  // At the final beat the burst in flight already counts as last served,
  // so back-to-back arbitration alternates without an idle bubble.
  always_comb begin
    arb_point  = (state_q == IDLE) || (beat_q == LAST_BEAT);
    last_is_rd = last_rd_q;
    if (state_q == RD_BURST) last_is_rd = 1'b1;
    if (state_q == WR_BURST) last_is_rd = 1'b0;
    grant_wr   = arb_point && wr_req && (!rd_req || last_is_rd);
    grant_rd   = arb_point && rd_req && !grant_wr;
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    addr_d    = addr_q;
    last_rd_d = last_rd_q;
    if (arb_point) begin
      if (state_q != IDLE) last_rd_d = (state_q == RD_BURST);
      beat_d = 4'd0;
      if (grant_wr) begin
        state_d = WR_BURST;
        addr_d  = wr_base;
      end else if (grant_rd) begin
        state_d = RD_BURST;
        addr_d  = rd_base;
      end else begin
        state_d = IDLE;
      end
    end else begin
      beat_d = beat_q + 4'd1;
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q    <= IDLE;
      beat_q     <= 4'd0;
      addr_q     <= '0;
      last_rd_q  <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      addr_q     <= addr_d;
      last_rd_q  <= last_rd_d;
      rd_valid_q <= (state_q == RD_BURST);
    end
  end

  // Buffer output is already registered; gating keeps rd_data at 0 when idle/reset.
  always_comb begin
    wr_gnt    = 1'b0;
    wr_beat   = 1'b0;
    rd_gnt    = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      WR_BURST: begin
        wr_gnt    = 1'b1;
        wr_beat   = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wr_data;
      end
      RD_BURST: begin
        rd_gnt   = 1'b1;
        mem_en   = 1'b1;
        mem_addr = addr_q;
      end
      default: ;
    endcase
    busy     = wr_gnt | rd_gnt;
    rd_valid = rd_valid_q;
    rd_data  = rd_valid_q ? mem_rdata : '0;
  end

endmodule
`default_nettype wire
